// File: rtl/conv_pkg.sv
// conv_pkg: shared state type, width defaults and window packing helper for the convolution fetch path
package conv_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int ADDR_SIZE  = 4;

    typedef enum logic [1:0] {IDLE, PRIME, STREAM, DRAIN} fetch_state_t;

    // Bit offset of pixel(r,c) inside a packed k x k window of dw-bit pixels
    function automatic int pix_lsb(input int r, input int c, input int k, input int dw);
        return (r * k + c) * dw;
    endfunction
endpackage

// File: rtl/conv_window_shift.sv
// conv_window_shift: K x K sliding window register array with a 1-entry skid for a stalled column
//  shift_ok   in   window may take new columns this cycle
//  in1_valid  in   port-1 column arriving (oldest of the two ports)
//  in1_col    in   port-1 column, row k at [k*DATA_WIDTH]
//  in2_valid  in   port-2 column arriving
//  in2_col    in   port-2 column, same packing
//  n_shift    out  number of columns shifted into the window this cycle
//  skid_full  out  a port-1 column is parked waiting for the window
//  win_data   out  pixel(r,c) at [(r*KERNEL_SIZE+c)*DATA_WIDTH], c=0 oldest
module conv_window_shift #(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_WIDTH  = conv_pkg::DATA_WIDTH
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       shift_ok,
    input  logic                                       in1_valid,
    input  logic [KERNEL_SIZE*DATA_WIDTH-1:0]          in1_col,
    input  logic                                       in2_valid,
    input  logic [KERNEL_SIZE*DATA_WIDTH-1:0]          in2_col,
    output logic [1:0]                                 n_shift,
    output logic                                       skid_full,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] win_data
);
    import conv_pkg::*;

    localparam int CW = KERNEL_SIZE * DATA_WIDTH;

    // Index 0 holds the oldest column
    typedef logic [KERNEL_SIZE-1:0][CW-1:0] win_t;

    win_t          win_q, win_d;
    logic [CW-1:0] skid_q, skid_d;
    logic          skid_full_d;

    function automatic win_t push(input win_t w, input logic [CW-1:0] col);
        return {col, w[KERNEL_SIZE-1:1]};
    endfunction

    // Columns enter strictly oldest first: parked skid column, then port 1, then port 2
    always_comb begin
        win_d       = win_q;
        skid_d      = skid_q;
        skid_full_d = skid_full;
        n_shift     = 2'd0;
        if (shift_ok && skid_full) begin
            win_d       = push(win_d, skid_q);
            skid_full_d = 1'b0;
            n_shift     = n_shift + 2'd1;
        end
        if (in1_valid && shift_ok) begin
            win_d   = push(win_d, in1_col);
            n_shift = n_shift + 2'd1;
        end else if (in1_valid) begin
            skid_d      = in1_col;
            skid_full_d = 1'b1;
        end
        if (in2_valid && shift_ok) begin
            win_d   = push(win_d, in2_col);
            n_shift = n_shift + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q     <= '0;
            skid_q    <= '0;
            skid_full <= 1'b0;
        end else begin
            win_q     <= win_d;
            skid_q    <= skid_d;
            skid_full <= skid_full_d;
        end
    end

    for (genvar r = 0; r < KERNEL_SIZE; r++) begin : g_row
        for (genvar c = 0; c < KERNEL_SIZE; c++) begin : g_col
            assign win_data[pix_lsb(r, c, KERNEL_SIZE, DATA_WIDTH) +: DATA_WIDTH] = win_q[c][r*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // The fetcher only issues when the skid is empty, so a column is never dropped
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(!shift_ok && ((in1_valid && skid_full) || in2_valid)));
endmodule

// File: rtl/conv_window_fetcher.sv
// conv_window_fetcher: drives the shared bank read ports and streams KxK sliding windows to the MAC array
//  start        in   pulse: fetch one row pass, ignored while busy
//  rd_en_*      out  read enables common to all banks
//  rd_addr_*    out  column addresses common to all banks
//  bank_data_*  in   1-cycle-latency bank read data, bank k at [k*DATA_WIDTH]
//  win_valid    out  window present;  win_ready in: consumer accepts
//  win_data     out  window pixels;   win_col out: leftmost column; win_last out: final window
//  busy         out  pass in progress; done out: pulse after the last handshake
module conv_window_fetcher #(
    parameter int IMAGE_SIZE  = 16,
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_WIDTH  = conv_pkg::DATA_WIDTH,
    parameter int ADDR_SIZE   = conv_pkg::ADDR_SIZE
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          start,
    output logic                                          rd_en_1,
    output logic [ADDR_SIZE-1:0]                          rd_addr_1,
    output logic                                          rd_en_2,
    output logic [ADDR_SIZE-1:0]                          rd_addr_2,
    input  logic [KERNEL_SIZE*DATA_WIDTH-1:0]             bank_data_1,
    input  logic [KERNEL_SIZE*DATA_WIDTH-1:0]             bank_data_2,
    output logic                                          win_valid,
    input  logic                                          win_ready,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] win_data,
    output logic [ADDR_SIZE-1:0]                          win_col,
    output logic                                          win_last,
    output logic                                          busy,
    output logic                                          done
);
    import conv_pkg::*;

    // One extra bit so the captured-column count can reach IMAGE_SIZE
    localparam int CNT_W = ADDR_SIZE + 1;
    localparam logic [CNT_W-1:0]     ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0]     TWO      = CNT_W'(2);
    localparam logic [CNT_W-1:0]     K_C      = CNT_W'(KERNEL_SIZE);
    localparam logic [CNT_W-1:0]     K_M1     = CNT_W'(KERNEL_SIZE - 1);
    localparam logic [CNT_W-1:0]     K_M2     = CNT_W'(KERNEL_SIZE - 2);
    localparam logic [CNT_W-1:0]     LAST_COL = CNT_W'(IMAGE_SIZE - 1);
    localparam logic [ADDR_SIZE-1:0] LAST_WIN = ADDR_SIZE'(IMAGE_SIZE - KERNEL_SIZE);

    fetch_state_t     state, state_d;
    logic [CNT_W-1:0] ic, ic_d, cnt, cnt_d;
    logic             p1_v, p2_v, valid_d, done_d, issue_ok, shift_ok, skid_full;
    logic [1:0]       n_shift;

    assign shift_ok = !win_valid || win_ready;
    // Only issue when the returning column is guaranteed a place (window or empty skid)
    assign issue_ok = !skid_full && !(win_valid && !win_ready);

    always_comb begin
        state_d = state;
        ic_d    = ic;
        rd_en_1 = 1'b0;
        rd_en_2 = 1'b0;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = PRIME;
                    ic_d    = '0;
                end
            end
            PRIME: begin
                rd_en_1 = 1'b1;
                // Port 2 only reads while its column still belongs to the priming set
                rd_en_2 = (ic + ONE) <= K_M2;
                if (ic + TWO >= K_M1) begin
                    state_d = STREAM;
                    ic_d    = K_M1;
                end else begin
                    ic_d = ic + TWO;
                end
            end
            STREAM: begin
                rd_en_1 = issue_ok;
                if (issue_ok) begin
                    state_d = (ic == LAST_COL) ? DRAIN : STREAM;
                    ic_d    = (ic == LAST_COL) ? ic : ic + ONE;
                end
            end
            DRAIN: begin
                if (win_valid && win_ready && win_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_addr_1 = rd_en_1 ? ADDR_SIZE'(ic) : '0;
    assign rd_addr_2 = rd_en_2 ? ADDR_SIZE'(ic + ONE) : '0;

    assign cnt_d   = (state == IDLE && start) ? '0 : cnt + CNT_W'(n_shift);
    // A presented window survives a handshake only if a fresh column replaces it
    assign valid_d = (cnt_d >= K_C) && (n_shift != 2'd0 || (win_valid && !win_ready));

    assign win_col  = win_valid ? ADDR_SIZE'(cnt - K_C) : '0;
    assign win_last = win_valid && (win_col == LAST_WIN);
    assign busy     = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ic        <= '0;
            cnt       <= '0;
            p1_v      <= 1'b0;
            p2_v      <= 1'b0;
            win_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            ic        <= ic_d;
            cnt       <= cnt_d;
            p1_v      <= rd_en_1;
            p2_v      <= rd_en_2;
            win_valid <= valid_d;
            done      <= done_d;
        end
    end

    conv_window_shift #(
        .KERNEL_SIZE (KERNEL_SIZE),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift_ok  (shift_ok),
        .in1_valid (p1_v),
        .in1_col   (bank_data_1),
        .in2_valid (p2_v),
        .in2_col   (bank_data_2),
        .n_shift   (n_shift),
        .skid_full (skid_full),
        .win_data  (win_data)
    );
endmodule

// File: tb/tb_conv_window_fetcher.sv
// tb_conv_window_fetcher: randomized self-checking bench with a bank memory and window reference model
module tb_conv_window_fetcher;
    localparam int K  = 3;
    localparam int IS = 16;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NW = IS - K + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              win_ready = 1'b0;
    logic              rd_en_1, rd_en_2, win_valid, win_last, busy, done;
    logic [AW-1:0]     rd_addr_1, rd_addr_2, win_col;
    logic [K*DW-1:0]   bank_data_1, bank_data_2;
    logic [K*K*DW-1:0] win_data;

    logic [DW-1:0] mem [K][IS];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_window_fetcher #(
        .IMAGE_SIZE  (IS),
        .KERNEL_SIZE (K),
        .DATA_WIDTH  (DW),
        .ADDR_SIZE   (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .rd_en_1     (rd_en_1),
        .rd_addr_1   (rd_addr_1),
        .rd_en_2     (rd_en_2),
        .rd_addr_2   (rd_addr_2),
        .bank_data_1 (bank_data_1),
        .bank_data_2 (bank_data_2),
        .win_valid   (win_valid),
        .win_ready   (win_ready),
        .win_data    (win_data),
        .win_col     (win_col),
        .win_last    (win_last),
        .busy        (busy),
        .done        (done)
    );

    // Line banks: 1-cycle read latency, zero data when not enabled
    always @(posedge clk) begin
        for (int k = 0; k < K; k++) begin
            bank_data_1[k*DW +: DW] <= rd_en_1 ? mem[k][rd_addr_1] : '0;
            bank_data_2[k*DW +: DW] <= rd_en_2 ? mem[k][rd_addr_2] : '0;
        end
    end

    // Window w covers image columns w..w+K-1 of every row
    function automatic logic [K*K*DW-1:0] exp_win(input int w);
        logic [K*K*DW-1:0] v;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                v[(r*K+c)*DW +: DW] = mem[r][w+c];
        return v;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        win_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({rd_en_1, rd_addr_1, rd_en_2, rd_addr_2, win_valid, win_col, win_last, busy, done, win_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: en1=%b a1=%0d en2=%b a2=%0d valid=%b col=%0d last=%b busy=%b done=%b data=%h, expected all zero",
                     rd_en_1, rd_addr_1, rd_en_2, rd_addr_2, win_valid, win_col, win_last, busy, done, win_data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, win_valid, rd_en_1, done} !== 4'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b valid=%b en1=%b done=%b, expected 0000", busy, win_valid, rd_en_1, done);
        end
    endtask

    // mode 0: ready=1, 1: ready low 5 cycles at window 4, 2: ready toggling,
    // 3: random ready, 4: ready=1 with start pulsed while busy
    task automatic test_stream(input string name, input int mode, input bit chain, input bit prestarted);
        int exp = 0;
        int cyc = 0;
        int stall = 0;
        int last_hs = -100;
        int first = -1;
        int wi;
        bit fin = 0;
        logic v, l, bz, dn;
        logic [AW-1:0] col;
        logic [K*K*DW-1:0] d;
        if (!prestarted) begin
            @(negedge clk);
            start = 1'b1;
            win_ready = 1'b1;
        end
        while (!fin && cyc < 600) begin
            @(negedge clk);
            cyc++;
            v = win_valid;
            col = win_col;
            l = win_last;
            d = win_data;
            bz = busy;
            dn = done;
            start = (mode == 4) && bz && (exp < NW - 3) && ($urandom_range(0, 2) == 0);
            case (mode)
                1: win_ready = !(exp == 4 && stall < 5);
                2: win_ready = !win_ready;
                3: win_ready = $urandom_range(0, 3) != 0;
                default: win_ready = 1'b1;
            endcase
            if (v && !win_ready && exp == 4) stall++;
            #1;
            if (cyc == 1) begin
                checks++;
                if ({rd_en_1, rd_en_2, rd_addr_1, rd_addr_2, bz} !== {1'b1, 1'b1, 4'd0, 4'd1, 1'b1}) begin
                    errors++;
                    $display("FAIL %s prime_cycle: en1=%b en2=%b a1=%0d a2=%0d busy=%b, expected 1 1 0 1 1",
                             name, rd_en_1, rd_en_2, rd_addr_1, rd_addr_2, bz);
                end
            end
            if (cyc == 2) begin
                checks++;
                if ({rd_en_1, rd_en_2, rd_addr_1} !== {1'b1, 1'b0, 4'd2}) begin
                    errors++;
                    $display("FAIL %s stream_first: en1=%b en2=%b a1=%0d, expected 1 0 2", name, rd_en_1, rd_en_2, rd_addr_1);
                end
            end
            if (v && first < 0) first = cyc;
            if (v) begin
                wi = (exp < NW) ? exp : NW - 1;
                checks++;
                if (exp >= NW || col !== AW'(exp) || l !== (exp == NW - 1) || d !== exp_win(wi)) begin
                    errors++;
                    $display("FAIL %s window_%0d: col=%0d last=%b data=%h, expected col=%0d last=%b data=%h",
                             name, exp, col, l, d, exp, exp == NW - 1, exp_win(wi));
                end
                if (win_ready) begin
                    exp++;
                    last_hs = cyc;
                end
            end
            if (v && !win_ready) begin
                checks++;
                if (rd_en_1 !== 1'b0) begin
                    errors++;
                    $display("FAIL %s stall_read: en1=%b while window stalled, expected 0", name, rd_en_1);
                end
            end
            if (dn) begin
                checks++;
                if (exp != NW || last_hs != cyc - 1 || bz !== 1'b0 || first != 4) begin
                    errors++;
                    $display("FAIL %s done: windows=%0d last_hs=%0d done_cyc=%0d busy=%b first_valid=%0d, expected %0d windows, done 1 after last, busy 0, first 4",
                             name, exp, last_hs, cyc, bz, first, NW);
                end
                fin = 1;
                if (chain) start = 1'b1;
            end
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no done after %0d cycles, windows=%0d, expected %0d", name, cyc, exp, NW);
        end
        if (!chain) begin
            repeat (3) begin
                @(negedge clk);
                checks++;
                if ({busy, win_valid, rd_en_1, done} !== 4'b0) begin
                    errors++;
                    $display("FAIL %s idle_after: busy=%b valid=%b en1=%b done=%b, expected 0000", name, busy, win_valid, rd_en_1, done);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int cyc = 0;
        @(negedge clk);
        start = 1'b1;
        win_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!(win_valid && win_col == 4'd7) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!(win_valid && win_col == 4'd7)) begin
            errors++;
            $display("FAIL mid_reset_reach: valid=%b col=%0d, expected window 7 within 100 cycles", win_valid, win_col);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_en_1, rd_addr_1, rd_en_2, rd_addr_2, win_valid, win_col, win_last, busy, done, win_data} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: en1=%b a1=%0d valid=%b col=%0d busy=%b data=%h, expected all zero",
                     rd_en_1, rd_addr_1, win_valid, win_col, busy, win_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, win_valid, rd_en_1} !== 3'b0) begin
            errors++;
            $display("FAIL mid_reset_idle: busy=%b valid=%b en1=%b, expected 000", busy, win_valid, rd_en_1);
        end
    endtask

    task automatic test_back_to_back();
        test_stream("b2b_pass1", 0, 1'b1, 1'b0);
        test_stream("b2b_pass2", 0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int p = 0; p < 3; p++) begin
            for (int r = 0; r < K; r++)
                for (int c = 0; c < IS; c++)
                    mem[r][c] = DW'($urandom);
            test_stream("random", (p == 1) ? 2 : 3, 1'b0, 1'b0);
        end
    endtask

    initial begin
        for (int r = 0; r < K; r++)
            for (int c = 0; c < IS; c++)
                mem[r][c] = DW'(r * 16 + c);
        test_reset();
        test_stream("basic", 0, 1'b0, 1'b0);
        test_stream("stall", 1, 1'b0, 1'b0);
        test_stream("toggle", 2, 1'b0, 1'b0);
        test_mid_reset();
        test_stream("after_reset", 0, 1'b0, 1'b0);
        test_stream("busy_start", 4, 1'b0, 1'b0);
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
